// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store pipeline stage.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store mask/data placement and load extract/extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]        funct3,
  input  logic [2:0]        off,
  input  logic [XLEN-1:0]   st_data,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN/8-1:0] wmask,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   ld_data
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] sh;
  logic signed [7:0]  b_s;
  logic signed [15:0] h_s;
  logic signed [31:0] w_s;

  always_comb begin
    wdata = st_data << {off, 3'b000};
    sh    = rdata >> {off, 3'b000};
    b_s   = sh[7:0];
    h_s   = sh[15:0];
    w_s   = sh[31:0];

    case (funct3[1:0])
      2'b00:   wmask = NB'(1)  << off;
      2'b01:   wmask = NB'(3)  << off;
      2'b10:   wmask = NB'(15) << off;
      default: wmask = '1;
    endcase

    // Signed locals make the width casts sign-extend; unsigned slices zero-extend.
    case (funct3)
      F3_B:    ld_data = XLEN'(b_s);
      F3_H:    ld_data = XLEN'(h_s);
      F3_W:    ld_data = XLEN'(w_s);
      F3_BU:   ld_data = XLEN'(sh[7:0]);
      F3_HU:   ld_data = XLEN'(sh[15:0]);
      F3_WU:   ld_data = XLEN'(sh[31:0]);
      default: ld_data = sh;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Memory-access pipeline stage: request FSM, upstream stall and writeback register.
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              exu_valid,
  input  logic              exu_load_en,
  input  logic              exu_store_en,
  input  logic [2:0]        exu_funct3,
  input  logic [XLEN-1:0]   exu_alu_result,
  input  logic [XLEN-1:0]   exu_data_rs2,
  input  logic [XLEN-1:0]   exu_snxt_pc,
  input  logic              exu_wb_en,
  input  logic              exu_wb_alu_en,
  input  logic              exu_wb_spc_en,
  input  logic              exu_ebreak_en,
  input  logic [4:0]        exu_index_rd,
  input  logic [XLEN-1:0]   exu_pc,
  input  logic [31:0]       exu_instr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  output logic              lsu_stall,
  output logic              lsu_valid,
  output logic              lsu_wb_en,
  output logic [XLEN-1:0]   lsu_wb_data,
  output logic [4:0]        lsu_index_rd,
  output logic [XLEN-1:0]   lsu_pc,
  output logic [31:0]       lsu_instr,
  output logic              lsu_ebreak_en
);

  lsu_state_e state, state_nxt;
  logic memop, rsp_done;
  logic [XLEN/8-1:0] wmask_a;
  logic [XLEN-1:0]   ld_data, wb_data_c;

  logic            vld_p1, wb_en_p1, ebreak_p1;
  logic [XLEN-1:0] wb_data_p1, pc_p1;
  logic [4:0]      rd_p1;
  logic [31:0]     instr_p1;

  assign memop    = exu_valid & (exu_load_en | exu_store_en);
  assign rsp_done = (state == RSP) & mem_rsp_valid;
  // Held low during reset so a still-valid upstream memop cannot leak a request or stall.
  assign lsu_stall = rstn & memop & ~rsp_done;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3  (exu_funct3),
    .off     (exu_alu_result[2:0]),
    .st_data (exu_data_rs2),
    .rdata   (mem_rsp_rdata),
    .wmask   (wmask_a),
    .wdata   (mem_req_wdata),
    .ld_data (ld_data)
  );

  assign mem_req_wen   = exu_store_en;
  assign mem_req_addr  = {exu_alu_result[XLEN-1:3], 3'b000};
  assign mem_req_wmask = exu_store_en ? wmask_a : '0;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    mem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        mem_req_valid = memop;
        if (memop) state_nxt = mem_req_ready ? RSP : REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = RSP;
      end
      RSP: begin
        if (mem_rsp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rstn) mem_req_valid = 1'b0;
  end

  always_comb begin
    wb_data_c = '0;
    if (exu_load_en)        wb_data_c = ld_data;
    else if (exu_wb_spc_en) wb_data_c = exu_snxt_pc;
    else if (exu_wb_alu_en) wb_data_c = exu_alu_result;
  end

  // ---- p1: writeback register, bubble while stalled ----
  always_ff @(posedge clk) begin
    if (!rstn || lsu_stall) begin
      vld_p1     <= 1'b0;
      wb_en_p1   <= 1'b0;
      wb_data_p1 <= '0;
      rd_p1      <= '0;
      pc_p1      <= '0;
      instr_p1   <= '0;
      ebreak_p1  <= 1'b0;
    end else begin
      vld_p1     <= exu_valid;
      wb_en_p1   <= exu_valid & exu_wb_en & ~exu_store_en;
      wb_data_p1 <= wb_data_c;
      rd_p1      <= exu_index_rd;
      pc_p1      <= exu_pc;
      instr_p1   <= exu_instr;
      ebreak_p1  <= exu_ebreak_en;
    end
  end

  assign lsu_valid     = vld_p1;
  assign lsu_wb_en     = wb_en_p1;
  assign lsu_wb_data   = wb_data_p1;
  assign lsu_index_rd  = rd_p1;
  assign lsu_pc        = pc_p1;
  assign lsu_instr     = instr_p1;
  assign lsu_ebreak_en = ebreak_p1;

endmodule
